// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the CPU-side memory bus controller.
//   - CPU command codes
//   - controller FSM states
//   - read-data source select
//   - default MMIO addresses for the LED register and switch port
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        CmdNone  = 2'b00,
        CmdRead  = 2'b01,
        CmdWrite = 2'b10,
        CmdRsvd  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StWrite = 2'b01,
        StRead  = 2'b10,
        StResp  = 2'b11
    } state_e;

    // Where the READ->RESP edge takes its response data from.
    typedef enum logic [1:0] {
        RdRam  = 2'b00,
        RdSw   = 2'b01,
        RdZero = 2'b10
    } rd_src_e;

    localparam logic [8:0] LedAddrDefault = 9'h100;
    localparam logic [8:0] SwAddrDefault  = 9'h140;

endpackage

// File: rtl/mem_bus_ctrl_mmio.sv
// Address decode and LED register for mem_bus_ctrl.
// Configuration macro: MEM_BUS_MMIO_EN
//   defined   : LED_ADDR/SW_ADDR decode as MMIO; the LED register loads on led_we_i.
//   undefined : pure decode; LED/SW addresses fall into the unmapped range, led_o is 0.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   addr_i           CPU request address
//   led_we_i         load the LED register this cycle (accepted write to led address)
//   led_wdata_i      LED load value
//   ram_hit_o        address lies inside the RAM window
//   led_hit_o        address is the LED register
//   sw_hit_o         address is the switch port
//   unmapped_o       none of the above
//   led_o            LED register contents
module mem_bus_ctrl_mmio
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned       RAM_AW   = 8,
    parameter int unsigned       CPU_AW   = 9,
    parameter logic [CPU_AW-1:0] LED_ADDR = CPU_AW'(LedAddrDefault),
    parameter logic [CPU_AW-1:0] SW_ADDR  = CPU_AW'(SwAddrDefault)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CPU_AW-1:0] addr_i,
    input  logic              led_we_i,
    input  logic [7:0]        led_wdata_i,
    output logic              ram_hit_o,
    output logic              led_hit_o,
    output logic              sw_hit_o,
    output logic              unmapped_o,
    output logic [7:0]        led_o
);

    // RAM occupies 0 .. 2**RAM_AW-1: every bit above the RAM index must be clear.
    assign ram_hit_o  = ((addr_i >> RAM_AW) == '0);
    assign unmapped_o = ~(ram_hit_o | led_hit_o | sw_hit_o);

`ifdef MEM_BUS_MMIO_EN
    logic [7:0] led_d, led_q;

    assign led_hit_o = (addr_i == LED_ADDR);
    assign sw_hit_o  = (addr_i == SW_ADDR);

    always_comb begin
        led_d = led_q;
        if (led_we_i) begin
            led_d = led_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_q <= 8'h00;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o = led_q;
`else
    logic unused_mmio;

    assign led_hit_o   = 1'b0;
    assign sw_hit_o    = 1'b0;
    assign led_o       = 8'h00;
    assign unused_mmio = ^{clk_i, rst_i, led_we_i, led_wdata_i, LED_ADDR, SW_ADDR};
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-side memory controller in front of a negedge-clocked data RAM.
// One CPU request at a time over valid/ready; writes take 1 cycle in WRITE, reads go
// through READ (RAM samples ram_raddr at the mid-cycle negedge) and RESP (held until
// rsp_ready). Unmapped accesses set a sticky bad_addr flag.
// Configuration macro: MEM_BUS_MMIO_EN enables the LED/switch MMIO decode.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid/req_cmd/req_addr/req_wdata/req_ready   CPU request channel
//   rsp_valid/rsp_rdata/rsp_ready                    CPU read response channel
//   ram_raddr/ram_waddr/ram_write/ram_din/ram_dout   data RAM ports
//   led, sw                       MMIO LED register and switch inputs
//   bad_addr                      sticky unmapped-access flag
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       RAM_AW   = 8,
    parameter int unsigned       CPU_AW   = 9,
    parameter logic [CPU_AW-1:0] LED_ADDR = CPU_AW'(LedAddrDefault),
    parameter logic [CPU_AW-1:0] SW_ADDR  = CPU_AW'(SwAddrDefault)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [1:0]        req_cmd,
    input  logic [CPU_AW-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_ready,
    output logic [RAM_AW-1:0] ram_raddr,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [7:0]        led,
    input  logic [7:0]        sw,
    output logic              bad_addr
);

    state_e            state_d, state_q;
    rd_src_e           rd_src_d, rd_src_q;
    logic              req_ready_d, req_ready_q;
    logic              rsp_valid_d, rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
    logic [RAM_AW-1:0] ram_raddr_d, ram_raddr_q;
    logic [RAM_AW-1:0] ram_waddr_d, ram_waddr_q;
    logic              ram_write_d, ram_write_q;
    logic [DATA_W-1:0] ram_din_d, ram_din_q;
    logic              bad_addr_d, bad_addr_q;

    logic ram_hit, led_hit, sw_hit, unmapped;
    logic led_we;

    mem_bus_ctrl_mmio #(
        .RAM_AW   (RAM_AW),
        .CPU_AW   (CPU_AW),
        .LED_ADDR (LED_ADDR),
        .SW_ADDR  (SW_ADDR)
    ) u_mmio (
        .clk_i       (clk),
        .rst_i       (reset),
        .addr_i      (req_addr),
        .led_we_i    (led_we),
        .led_wdata_i (req_wdata[7:0]),
        .ram_hit_o   (ram_hit),
        .led_hit_o   (led_hit),
        .sw_hit_o    (sw_hit),
        .unmapped_o  (unmapped),
        .led_o       (led)
    );

    always_comb begin
        state_d     = state_q;
        rd_src_d    = rd_src_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_raddr_d = ram_raddr_q;
        ram_waddr_d = ram_waddr_q;
        ram_write_d = ram_write_q;
        ram_din_d   = ram_din_q;
        bad_addr_d  = bad_addr_q;
        led_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // MNONE and the reserved code fall through with no effect.
                if (req_valid && req_ready_q && (req_cmd == CmdWrite)) begin
                    state_d     = StWrite;
                    req_ready_d = 1'b0;
                    led_we      = led_hit;
                    if (ram_hit) begin
                        ram_write_d = 1'b1;
                        ram_waddr_d = req_addr[RAM_AW-1:0];
                        ram_din_d   = req_wdata;
                    end
                    if (unmapped) begin
                        bad_addr_d = 1'b1;
                    end
                end else if (req_valid && req_ready_q && (req_cmd == CmdRead)) begin
                    state_d     = StRead;
                    req_ready_d = 1'b0;
                    if (ram_hit) begin
                        ram_raddr_d = req_addr[RAM_AW-1:0];
                        rd_src_d    = RdRam;
                    end else if (sw_hit) begin
                        rd_src_d = RdSw;
                    end else begin
                        rd_src_d   = RdZero;
                        bad_addr_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                // RAM commits at the negedge inside this cycle.
                ram_write_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = StIdle;
            end
            StRead: begin
                // ram_dout has settled from the negedge sample of ram_raddr.
                unique case (rd_src_q)
                    RdRam:   rsp_rdata_d = ram_dout;
                    RdSw:    rsp_rdata_d = {{(DATA_W-8){1'b0}}, sw};
                    default: rsp_rdata_d = '0;
                endcase
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                ram_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rd_src_q    <= RdZero;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ram_raddr_q <= '0;
            ram_waddr_q <= '0;
            ram_write_q <= 1'b0;
            ram_din_q   <= '0;
            bad_addr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_src_q    <= rd_src_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_raddr_q <= ram_raddr_d;
            ram_waddr_q <= ram_waddr_d;
            ram_write_q <= ram_write_d;
            ram_din_q   <= ram_din_d;
            bad_addr_q  <= bad_addr_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_raddr = ram_raddr_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_write = ram_write_q;
    assign ram_din   = ram_din_q;
    assign bad_addr  = bad_addr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl with a negedge-clocked 16x256 RAM behind it.
// Expected values come from a transaction-level model: an array of RAM words, the LED
// value and the sticky error flag, updated per accepted request.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_cmd;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_ready;
    logic [7:0]  ram_raddr;
    logic [7:0]  ram_waddr;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [7:0]  led;
    logic [7:0]  sw;
    logic        bad_addr;

    mem_bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_ready (rsp_ready),
        .ram_raddr (ram_raddr),
        .ram_waddr (ram_waddr),
        .ram_write (ram_write),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .led       (led),
        .sw        (sw),
        .bad_addr  (bad_addr)
    );

    always #5 clk = ~clk;

    // Data RAM: negedge-clocked write and registered read.
    logic [15:0] ram [256];
    always @(negedge clk) begin
        if (ram_write) ram[ram_waddr] <= ram_din;
        ram_dout <= ram[ram_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model
    logic [15:0] model_mem [256];
    logic [7:0]  model_led;
    logic        model_bad;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // 0 = RAM, 1 = LED, 2 = switches, 3 = unmapped
    function automatic int addr_kind(input logic [8:0] a);
        if (a < 9'd256) return 0;
`ifdef MEM_BUS_MMIO_EN
        if (a == 9'h100) return 1;
        if (a == 9'h140) return 2;
`endif
        return 3;
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_cmd   = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
    endtask

    // Asserted just after a posedge; checks that outputs clear before any clock edge.
    task automatic pulse_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        model_bad = 1'b0;
        model_led = 8'h00;
        check_eq("rst_ram_write", ram_write, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_bad_addr", bad_addr, 0);
        check_eq("rst_led", led, 0);
        check_eq("rst_ram_raddr", ram_raddr, 0);
        check_eq("rst_ram_waddr", ram_waddr, 0);
        check_eq("rst_ram_din", ram_din, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [8:0] addr, input logic [15:0] data);
        int k;
        k = addr_kind(addr);
        check_eq("wr_ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = 2'b10;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_cmd   = 2'b00;
        check_eq("wr_pulse", ram_write, (k == 0));
        check_eq("wr_busy", req_ready, 0);
        check_eq("wr_no_rsp", rsp_valid, 0);
        if (k == 0) begin
            check_eq("wr_addr", ram_waddr, addr[7:0]);
            check_eq("wr_data", ram_din, data);
            model_mem[addr[7:0]] = data;
        end
        if (k == 1) model_led = data[7:0];
        if (k == 3) model_bad = 1'b1;
        check_eq("led", led, model_led);
        @(posedge clk);
        #1;
        check_eq("wr_end", ram_write, 0);
        check_eq("wr_ready_after", req_ready, 1);
        check_eq("bad_addr", bad_addr, model_bad);
    endtask

    task automatic do_read(input logic [8:0] addr, input int stall, output int acc_cyc);
        int          k;
        logic [15:0] exp;
        k   = addr_kind(addr);
        exp = (k == 0) ? model_mem[addr[7:0]] : (k == 2) ? {8'h00, sw} : 16'h0000;
        check_eq("rd_ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = 2'b01;
        req_addr  = addr;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_cmd   = 2'b00;
        check_eq("rd_not_yet", rsp_valid, 0);
        check_eq("rd_busy", req_ready, 0);
        check_eq("rd_no_write", ram_write, 0);
        @(posedge clk);
        #1;
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_rdata", rsp_rdata, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check_eq("stall_valid", rsp_valid, 1);
            check_eq("stall_rdata", rsp_rdata, exp);
            check_eq("stall_busy", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("rsp_done", rsp_valid, 0);
        check_eq("rd_ready_after", req_ready, 1);
        check_eq("rdata_held", rsp_rdata, exp);
        if (k == 3) model_bad = 1'b1;
        check_eq("bad_addr", bad_addr, model_bad);
        check_eq("led", led, model_led);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0, c1;
        int          r;
        logic [8:0]  a;
        logic [15:0] v;

        idle_inputs();
        sw    = 8'h00;
        reset = 1'b1;
        #2;
        pulse_reset();

        // Give every RAM word a known value through the controller.
        for (int i = 0; i < 256; i++) begin
            do_write(9'(i), 16'($urandom));
        end

        // Write then read back.
        do_write(9'h005, 16'hBEEF);
        do_read(9'h005, 0, c0);

        // Response held under backpressure.
        do_read(9'h0FF, 4, c0);

        // Unmapped write dropped, read returns 0, flag sticky.
        do_write(9'h1F0, 16'h1234);
        do_read(9'h1F0, 0, c0);
        do_write(9'h006, 16'h0606);
        check_eq("bad_sticky", bad_addr, 1);

        // MMIO, or unmapped when the option is off.
        pulse_reset();
        sw = 8'h3C;
        do_write(9'h100, 16'h00A5);
        do_read(9'h140, 1, c0);

        // Reset during WRITE: interrupted write never reaches the RAM.
        pulse_reset();
        do_write(9'h020, 16'hA5A5);
        req_valid = 1'b1;
        req_cmd   = 2'b10;
        req_addr  = 9'h020;
        req_wdata = 16'h5A5A;
        @(posedge clk);
        #1;
        check_eq("int_wr_pulse", ram_write, 1);
        pulse_reset();
        do_read(9'h020, 0, c0);

        // Reset during RESP.
        req_valid = 1'b1;
        req_cmd   = 2'b01;
        req_addr  = 9'h005;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("int_rsp_valid", rsp_valid, 1);
        pulse_reset();
        do_read(9'h005, 0, c0);

        // MNONE and reserved commands are ignored.
        for (int j = 0; j < 2; j++) begin
            req_valid = 1'b1;
            req_cmd   = (j == 0) ? 2'b00 : 2'b11;
            req_addr  = 9'h005;
            req_wdata = 16'hDEAD;
            repeat (2) @(posedge clk);
            #1;
            check_eq("nop_ready", req_ready, 1);
            check_eq("nop_rsp", rsp_valid, 0);
            check_eq("nop_write", ram_write, 0);
        end
        idle_inputs();
        do_read(9'h005, 0, c0);

        // Back-to-back reads are spaced by 3 cycles.
        do_read(9'h000, 0, c0);
        do_read(9'h001, 0, c1);
        check_eq("rd_spacing", c1 - c0, 3);

        // Back-to-back writes are spaced by 2 cycles.
        c0 = cyc;
        do_write(9'h010, 16'h1010);
        do_write(9'h011, 16'h1111);
        check_eq("wr_spacing", cyc - c0, 4);

        // Randomized mix against the model.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = {1'b0, 8'($urandom)};
            else if (r < 8) a = 9'($urandom);
            else if (r == 8) a = 9'h100;
            else            a = 9'h140;
            sw = 8'($urandom);
            v  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, v);
            else do_read(a, $urandom_range(0, 3), c0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
